// File: rtl/lh_pkg.sv
// Shared constants, types and helpers for the light-hash message framer.
package lh_pkg;

    localparam logic [7:0] LH_START_CHAR  = 8'hFF;
    localparam logic [7:0] LH_FINISH_CHAR = 8'h00;

    localparam logic [7:0] LH_ASCII_DIGIT_LO = 8'h30;
    localparam logic [7:0] LH_ASCII_DIGIT_HI = 8'h39;
    localparam logic [7:0] LH_ASCII_UPPER_LO = 8'h41;
    localparam logic [7:0] LH_ASCII_UPPER_HI = 8'h5A;
    localparam logic [7:0] LH_ASCII_LOWER_LO = 8'h61;
    localparam logic [7:0] LH_ASCII_LOWER_HI = 8'h7A;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SEND_START  = 3'd1,
        ST_FETCH       = 3'd2,
        ST_SEND_CHAR   = 3'd3,
        ST_SEND_FINISH = 3'd4,
        ST_WAIT_DIGEST = 3'd5
    } lh_state_e;

    // One buffered host byte with its end-of-message marker.
    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } lh_entry_t;

    localparam int unsigned LH_ENTRY_W = $bits(lh_entry_t);

    function automatic logic lh_is_alnum(input logic [7:0] c);
        return ((c >= LH_ASCII_DIGIT_LO) && (c <= LH_ASCII_DIGIT_HI)) ||
               ((c >= LH_ASCII_UPPER_LO) && (c <= LH_ASCII_UPPER_HI)) ||
               ((c >= LH_ASCII_LOWER_LO) && (c <= LH_ASCII_LOWER_HI));
    endfunction

endpackage

// File: rtl/lh_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered full/empty flags.
module lh_sync_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + (AW+1)'(1);
                full  <= (count == (AW+1)'(DEPTH - 1));
                empty <= 1'b0;
            end else if (pop_ok && !push_ok) begin
                count <= count - (AW+1)'(1);
                full  <= 1'b0;
                empty <= (count == (AW+1)'(1));
            end
        end
    end

endmodule

// File: rtl/lh_msg_framer.sv
// Frames a buffered host message as START, chars, FINISH for the light-hash core.
// Optional alphanumeric filter: define LH_FRAMER_ALNUM_CHECK_EN.
module lh_msg_framer #(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned ROUND_CYCLES = 34
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_char,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] ptxt_char,
    output logic       ptxt_valid,
    input  logic       digest_ready,
    output logic       busy,
    output logic [7:0] msg_len,
    output logic       err_invalid_char
);

    import lh_pkg::*;

    localparam int unsigned CNT_W = $clog2(ROUND_CYCLES);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(ROUND_CYCLES - 1);

    lh_state_e        state;
    lh_entry_t        wr_entry;
    lh_entry_t        rd_entry;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop_c;
    logic             keep_c;
    logic             slot_done_c;
    logic             dig_rise_c;
    logic [CNT_W-1:0] cnt;
    logic             cur_last;
    logic             dr_q;

    assign wr_entry = '{last: in_last, data: in_char};
    assign in_ready = ~fifo_full;
    assign pop_c    = (state == ST_FETCH) && !fifo_empty;

    lh_sync_fifo #(
        .WIDTH (LH_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .wdata (wr_entry),
        .pop   (pop_c),
        .rdata (rd_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef LH_FRAMER_ALNUM_CHECK_EN
    assign keep_c = lh_is_alnum(rd_entry.data);
`else
    assign keep_c = (rd_entry.data != LH_START_CHAR) && (rd_entry.data != LH_FINISH_CHAR);
`endif

    assign slot_done_c = (cnt == SLOT_LAST);
    assign dig_rise_c  = digest_ready & ~dr_q;

    // Framing FSM; every output is updated on the transition that enters a slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            cur_last         <= 1'b0;
            dr_q             <= 1'b0;
            ptxt_char        <= LH_FINISH_CHAR;
            ptxt_valid       <= 1'b0;
            busy             <= 1'b0;
            msg_len          <= '0;
            err_invalid_char <= 1'b0;
        end else begin
            dr_q       <= digest_ready;
            ptxt_valid <= 1'b0;
            cnt        <= cnt + CNT_W'(1);
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (!fifo_empty) begin
                        state            <= ST_SEND_START;
                        ptxt_char        <= LH_START_CHAR;
                        ptxt_valid       <= 1'b1;
                        busy             <= 1'b1;
                        msg_len          <= '0;
                        err_invalid_char <= 1'b0;
                    end
                end
                ST_SEND_START: begin
                    if (slot_done_c) begin
                        cnt   <= '0;
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    cnt <= '0;
                    if (!fifo_empty) begin
                        cur_last <= rd_entry.last;
                        if (keep_c) begin
                            state      <= ST_SEND_CHAR;
                            ptxt_char  <= rd_entry.data;
                            ptxt_valid <= 1'b1;
                            if (msg_len != 8'hFF) begin
                                msg_len <= msg_len + 8'd1;
                            end
                        end else begin
                            err_invalid_char <= 1'b1;
                            if (rd_entry.last) begin
                                state      <= ST_SEND_FINISH;
                                ptxt_char  <= LH_FINISH_CHAR;
                                ptxt_valid <= 1'b1;
                            end
                        end
                    end
                end
                ST_SEND_CHAR: begin
                    if (slot_done_c) begin
                        cnt <= '0;
                        if (cur_last) begin
                            state      <= ST_SEND_FINISH;
                            ptxt_char  <= LH_FINISH_CHAR;
                            ptxt_valid <= 1'b1;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_SEND_FINISH: begin
                    if (slot_done_c) begin
                        cnt   <= '0;
                        state <= ST_WAIT_DIGEST;
                    end
                end
                ST_WAIT_DIGEST: begin
                    if (dig_rise_c || slot_done_c) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lh_msg_framer.sv
// Randomized self-checking bench for lh_msg_framer against a message-level model.
module tb_lh_msg_framer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned RC    = 34;

    typedef logic [8:0] ent_q_t[$];

    logic       clk;
    logic       rst_n;
    logic [7:0] in_char;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] ptxt_char;
    logic       ptxt_valid;
    logic       digest_ready;
    logic       busy;
    logic [7:0] msg_len;
    logic       err_invalid_char;

    lh_msg_framer #(
        .FIFO_DEPTH   (DEPTH),
        .ROUND_CYCLES (RC)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_char          (in_char),
        .in_valid         (in_valid),
        .in_last          (in_last),
        .in_ready         (in_ready),
        .ptxt_char        (ptxt_char),
        .ptxt_valid       (ptxt_valid),
        .digest_ready     (digest_ready),
        .busy             (busy),
        .msg_len          (msg_len),
        .err_invalid_char (err_invalid_char)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every framed-byte strobe with the cycle it was seen in.
    logic [7:0] obs_c[$];
    int         obs_t[$];
    always @(negedge clk) begin
        if (rst_n && ptxt_valid) begin
            obs_c.push_back(ptxt_char);
            obs_t.push_back(cyc);
        end
    end

    int total = 0;
    int bad   = 0;
    int last_acc;
    int first_acc;
    int acc_cnt = 0;
    int stall_cnt = 0;
    int acc_at_first_stall = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_keep(input logic [7:0] c);
`ifdef LH_FRAMER_ALNUM_CHECK_EN
        return (c inside {[8'h30:8'h39], [8'h41:8'h5A], [8'h61:8'h7A]});
`else
        return (c != 8'h00) && (c != 8'hFF);
`endif
    endfunction

    function automatic logic [7:0] rand_alnum();
        int unsigned r;
        r = $urandom_range(61, 0);
        if (r < 10) return 8'(8'h30 + r);
        if (r < 36) return 8'(8'h41 + r - 10);
        return 8'(8'h61 + r - 36);
    endfunction

    function automatic logic [7:0] rand_byte();
        logic [7:0] punct[5];
        int unsigned r;
        punct = '{8'h23, 8'h21, 8'h40, 8'h20, 8'h2D};
        r = $urandom_range(9, 0);
        if (r == 0) return 8'h00;
        if (r == 1) return 8'hFF;
        if (r == 2) return punct[$urandom_range(4, 0)];
        return rand_alnum();
    endfunction

    task automatic push_byte(input logic [7:0] c, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_char  = c;
        in_last  = l;
        while (!in_ready && n < 5000) begin
            if (acc_at_first_stall < 0) acc_at_first_stall = acc_cnt;
            stall_cnt++;
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
        last_acc = cyc;
        acc_cnt++;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle_after(input int n_strobes);
        int n;
        n = 0;
        while ((obs_c.size() < n_strobes || busy) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Push a whole message, then compare the framed stream and status to the model.
    task automatic run_msg(input string tag, input ent_q_t msg, input int max_gap);
        logic [7:0] exp_c[$];
        int kept;
        bit dropped;
        kept = 0;
        dropped = 1'b0;
        obs_c.delete();
        obs_t.delete();
        exp_c.push_back(8'hFF);
        foreach (msg[i]) begin
            if (ref_keep(msg[i][7:0])) begin
                exp_c.push_back(msg[i][7:0]);
                kept++;
            end else begin
                dropped = 1'b1;
            end
        end
        exp_c.push_back(8'h00);
        foreach (msg[i]) begin
            push_byte(msg[i][7:0], msg[i][8]);
            if (i == 0) first_acc = last_acc;
            if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        end
        wait_idle_after(exp_c.size());
        check({tag, "_nbytes"}, 32'(obs_c.size()), 32'(exp_c.size()));
        for (int i = 0; i < exp_c.size() && i < obs_c.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), 32'(obs_c[i]), 32'(exp_c[i]));
        end
        check({tag, "_msg_len"}, 32'(msg_len), 32'((kept > 255) ? 255 : kept));
        check({tag, "_err"}, 32'(err_invalid_char), 32'(dropped));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        ent_q_t m;
        int n;
        int acc;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_char      = 8'h00;
        in_last      = 1'b0;
        digest_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(ptxt_valid), 32'd0);
        check("rst_char", 32'(ptxt_char), 32'd0);
        check("rst_len", 32'(msg_len), 32'd0);
        check("rst_err", 32'(err_invalid_char), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // "Ab1" back-to-back: content plus slot timing.
        m = '{9'h041, 9'h062, 9'h131};
        run_msg("ab1", m, 0);
        if (obs_t.size() >= 5) begin
            check("ab1_first_lat", 32'(obs_t[0] - first_acc), 32'd2);
            check("ab1_gap01", 32'(obs_t[1] - obs_t[0]), 32'(RC + 1));
            check("ab1_gap12", 32'(obs_t[2] - obs_t[1]), 32'(RC + 1));
            check("ab1_gap23", 32'(obs_t[3] - obs_t[2]), 32'(RC + 1));
            check("ab1_gap34", 32'(obs_t[4] - obs_t[3]), 32'(RC));
            check("ab1_wait_timeout", 32'(cyc - obs_t[4]), 32'(2 * RC));
        end

        m = '{9'h041, 9'h023, 9'h162};
        run_msg("a_hash_b", m, 2);

        m = '{9'h100};
        run_msg("only_zero", m, 0);

        // 20 bytes back-to-back into a 16-deep FIFO.
        m.delete();
        for (int i = 0; i < 20; i++) m.push_back({(i == 19) ? 1'b1 : 1'b0, rand_alnum()});
        acc_cnt = 0;
        stall_cnt = 0;
        acc_at_first_stall = -1;
        run_msg("burst20", m, 0);
        check("burst20_stalled", 32'(stall_cnt > 0), 32'd1);
        check("burst20_depth", 32'(acc_at_first_stall), 32'(DEPTH));

        // Host stall after 'A' leaves the framer in FETCH.
        obs_c.delete();
        obs_t.delete();
        push_byte(8'h41, 1'b0);
        repeat (100) @(negedge clk);
        check("stall_nbytes", 32'(obs_c.size()), 32'd2);
        check("stall_valid", 32'(ptxt_valid), 32'd0);
        check("stall_hold", 32'(ptxt_char), 32'h41);
        check("stall_busy", 32'(busy), 32'd1);
        push_byte(8'h42, 1'b1);
        acc = last_acc;
        wait_idle_after(4);
        check("stall_after_n", 32'(obs_c.size()), 32'd4);
        check("stall_b_char", 32'(obs_c[2]), 32'h42);
        check("stall_b_lat", 32'(obs_t[2] - acc), 32'd2);
        check("stall_fin", 32'(obs_c[3]), 32'h00);
        check("stall_len", 32'(msg_len), 32'd2);

        // Early exit from the digest wait on a digest_ready rising edge.
        obs_c.delete();
        obs_t.delete();
        push_byte(8'h5A, 1'b1);
        n = 0;
        while (obs_c.size() < 3 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (RC + 3) @(negedge clk);
        check("dig_busy_before", 32'(busy), 32'd1);
        digest_ready = 1'b1;
        @(negedge clk);
        check("dig_busy_after", 32'(busy), 32'd0);
        digest_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Randomized messages.
        for (int k = 0; k < 8; k++) begin
            int len;
            len = $urandom_range(8, 1);
            m.delete();
            for (int i = 0; i < len; i++) m.push_back({(i == len - 1) ? 1'b1 : 1'b0, rand_byte()});
            run_msg($sformatf("rnd%0d", k), m, 3);
        end

        // Asynchronous reset in the middle of a char slot flushes everything.
        obs_c.delete();
        obs_t.delete();
        push_byte(8'h41, 1'b0);
        push_byte(8'h42, 1'b0);
        push_byte(8'h43, 1'b0);
        push_byte(8'h44, 1'b1);
        n = 0;
        while (obs_c.size() < 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check("pre_rst_len", 32'(msg_len), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(ptxt_valid), 32'd0);
        check("mid_rst_char", 32'(ptxt_char), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_len", 32'(msg_len), 32'd0);
        check("mid_rst_err", 32'(err_invalid_char), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        obs_c.delete();
        obs_t.delete();
        repeat (10) @(negedge clk);
        check("post_rst_quiet", 32'(obs_c.size()), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
